fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the main control decoder.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid interface.
- Holds the fetched instruction in an IF/ID register with a valid/ready handshake toward decode.
- id_opcode drives the decoder's opcode input; branch redirects flush in-flight work.

---
 rtl/fetch_stage_pkg.sv | 32 +++
 rtl/fetch_stage_if_id_reg.sv | 76 +++++++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared types and constants for the instruction-fetch stage and the main
// control decoder that consumes its opcode output.
//   fetch_state_e : fetch FSM states
//   OP_*          : primary opcode values (instr[31:26])
//   INSTR_W       : instruction width
//   opcode_of()   : extracts the primary opcode field from an instruction
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with a one-entry skid slot and valid/ready logic.
//   clk, rst_n     : clock, async active-low reset
//   flush          : redirect; empties IF/ID and skid (highest priority)
//   load           : a fetched instruction arrives this cycle
//   load_instr/pc  : the arriving instruction and its address
//   id_ready       : decode consumes IF/ID this cycle
//   accept         : IF/ID can take a load directly (else it goes to skid)
//   id_valid/instr/pc/pc_plus4 : IF/ID contents toward decode
// ---------------------------------------------------------------------------
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic               id_ready,
  output logic               accept,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4
);

  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  // A load can go straight into IF/ID when it is empty or being drained.
  assign accept = !id_valid || id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the skid data is reset along with its valid bit so every IF/ID
      // field reads a defined value after reset; it is one entry, not an array.
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
    end else if (flush) begin
      // NOTE: non-blocking assignments keep every register update in this
      // block reading the pre-edge values, independent of statement order.
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load) begin
      if (accept) begin
        id_valid    <= 1'b1;
        id_instr    <= load_instr;
        id_pc       <= load_pc;
        id_pc_plus4 <= load_pc + ADDR_W'(4);
      end else begin
        skid_valid <= 1'b1;
        skid_instr <= load_instr;
        skid_pc    <= load_pc;
      end
    end else if (skid_valid && id_ready) begin
      // Current IF/ID is consumed and replaced by the skid entry; id_valid stays 1.
      id_instr    <= skid_instr;
      id_pc       <= skid_pc;
      id_pc_plus4 <= skid_pc + ADDR_W'(4);
      skid_valid  <= 1'b0;
    end else if (id_valid && id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, fetches words over req/gnt/rvalid and
// presents them to decode through the IF/ID register.
//   clk, rst_n                : clock, async active-low reset
//   imem_req/imem_addr        : registered fetch request and word address
//   imem_gnt                  : memory accepts the request
//   imem_rvalid/imem_rdata    : one response per granted request
//   branch_taken/target       : redirect pulse and address (low bits ignored)
//   id_ready                  : decode accepts IF/ID
//   id_valid/instr/pc/pc_plus4: IF/ID contents
//   id_opcode                 : id_instr[31:26] for the main decoder
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  input  logic                id_ready,
  output logic                id_valid,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [ADDR_W-1:0]   id_pc,
  output logic [ADDR_W-1:0]   id_pc_plus4,
  output logic [OPCODE_W-1:0] id_opcode
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fetch_pc;
  logic              drop;
  logic              accept;
  logic              load;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] redirect_pc;

  assign pc_plus4    = pc + ADDR_W'(4);
  assign redirect_pc = {branch_target[ADDR_W-1:2], 2'b00};

  // Only a live (not dropped, not flushed) response reaches IF/ID.
  assign load = (state == S_WAIT) && imem_rvalid && !drop && !branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= PC_RESET;
      fetch_pc  <= '0;
      drop      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= PC_RESET;
    end else if (branch_taken) begin
      pc        <= redirect_pc;
      imem_addr <= redirect_pc;
      unique case (state)
        S_REQ: begin
          // A granted request is already in flight; its response is dropped.
          if (imem_gnt) begin
            state    <= S_WAIT;
            drop     <= 1'b1;
            imem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state    <= S_REQ;
            drop     <= 1'b0;
            imem_req <= 1'b1;
          end else begin
            drop <= 1'b1;
          end
        end
        S_IDLE, S_HOLD: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
      endcase
    end else begin
      unique case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          if (imem_gnt) begin
            fetch_pc  <= pc;
            pc        <= pc_plus4;
            imem_addr <= pc_plus4;
            imem_req  <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (drop || accept) begin
              state    <= S_REQ;
              imem_req <= 1'b1;
            end else begin
              // Response parked in the skid slot; no new request until it drains.
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W(ADDR_W)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (branch_taken),
    .load       (load),
    .load_instr (imem_rdata),
    .load_pc    (fetch_pc),
    .id_ready   (id_ready),
    .accept     (accept),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4)
  );

  assign id_opcode = opcode_of(id_instr);

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Two fetch stages: dut0 (PC_RESET=0) runs the directed scenario under a
// program-order model; dut1 (PC_RESET=FFFF_FFFC) covers PC wrap-around.
// Each has a small instruction memory with configurable grant and latency.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_ready1;
  logic        branch_taken1;
  logic [31:0] branch_target1;

  logic        imem_req    [2];
  logic [31:0] imem_addr   [2];
  logic        imem_gnt    [2];
  logic        imem_rvalid [2];
  logic [31:0] imem_rdata  [2];
  logic        id_valid    [2];
  logic [31:0] id_instr    [2];
  logic [31:0] id_pc       [2];
  logic [31:0] id_pc_plus4 [2];
  logic [5:0]  id_opcode   [2];

  logic        gnt_en  [2];
  int          mem_lat [2];

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(32), .PC_RESET(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req[0]), .imem_addr(imem_addr[0]), .imem_gnt(imem_gnt[0]),
    .imem_rvalid(imem_rvalid[0]), .imem_rdata(imem_rdata[0]),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_ready(id_ready), .id_valid(id_valid[0]), .id_instr(id_instr[0]),
    .id_pc(id_pc[0]), .id_pc_plus4(id_pc_plus4[0]), .id_opcode(id_opcode[0])
  );

  fetch_stage #(.ADDR_W(32), .PC_RESET(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req[1]), .imem_addr(imem_addr[1]), .imem_gnt(imem_gnt[1]),
    .imem_rvalid(imem_rvalid[1]), .imem_rdata(imem_rdata[1]),
    .branch_taken(branch_taken1), .branch_target(branch_target1),
    .id_ready(id_ready1), .id_valid(id_valid[1]), .id_instr(id_instr[1]),
    .id_pc(id_pc[1]), .id_pc_plus4(id_pc_plus4[1]), .id_opcode(id_opcode[1])
  );

  // Program image: instruction content is a pure function of its address.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    logic [5:0] op;
    case (a[4:2])
      3'd0:    op = OP_LW;
      3'd1:    op = OP_RTYPE;
      3'd2:    op = OP_SW;
      3'd3:    op = OP_BEQ;
      3'd4:    op = OP_ADDI;
      3'd5:    op = OP_LW;
      3'd6:    op = OP_SW;
      default: op = OP_BEQ;
    endcase
    return {op, 10'h008, 16'h0004 ^ a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memories: grant gated by gnt_en, response mem_lat cycles later.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    logic        busy;
    int          cnt;
    logic [31:0] paddr;

    assign imem_gnt[g] = imem_req[g] & gnt_en[g];

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy           <= 1'b0;
        cnt            <= 0;
        paddr          <= '0;
        imem_rvalid[g] <= 1'b0;
        imem_rdata[g]  <= '0;
      end else begin
        imem_rvalid[g] <= 1'b0;
        if (busy && cnt == 1) begin
          imem_rvalid[g] <= 1'b1;
          imem_rdata[g]  <= instr_at(paddr);
          busy           <= 1'b0;
        end else if (busy) begin
          cnt <= cnt - 1;
        end
        if (imem_gnt[g]) begin
          if (mem_lat[g] <= 1) begin
            imem_rvalid[g] <= 1'b1;
            imem_rdata[g]  <= instr_at(imem_addr[g]);
          end else begin
            busy  <= 1'b1;
            cnt   <= mem_lat[g] - 1;
            paddr <= imem_addr[g];
          end
        end
      end
    end
  end

  // Model: instructions handed to decode must follow program order from the
  // reset PC or the last redirect, each exactly once, with content matching
  // its address; a pending request holds its address until granted.
  logic [31:0] exp_pc;
  logic        prev_hold;
  logic [31:0] prev_addr;
  logic        prev_branch;

  always @(negedge clk) begin
    logic [31:0] ei;
    if (!rst_n) begin
      exp_pc      = 32'h0;
      prev_hold   = 1'b0;
      prev_addr   = '0;
      prev_branch = 1'b0;
    end else begin
      if (id_valid[0]) begin
        ei = instr_at(id_pc[0]);
        check("m_instr", id_instr[0], ei);
        check("m_pc_plus4", id_pc_plus4[0], id_pc[0] + 32'd4);
        check("m_opcode", {26'd0, id_opcode[0]}, {26'd0, ei[31:26]});
      end
      if (imem_req[0]) check("m_addr_align", {30'd0, imem_addr[0][1:0]}, 32'd0);
      if (prev_hold) begin
        check("m_req_held", {31'd0, imem_req[0]}, 32'd1);
        check("m_addr_held", imem_addr[0], prev_addr);
      end
      if (prev_branch) check("m_flush", {31'd0, id_valid[0]}, 32'd0);
      if (branch_taken) begin
        exp_pc = {branch_target[31:2], 2'b00};
      end else if (id_valid[0] && id_ready) begin
        check("m_order", id_pc[0], exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (id_valid[1]) begin
        ei = instr_at(id_pc[1]);
        check("m1_instr", id_instr[1], ei);
        check("m1_pc_plus4", id_pc_plus4[1], id_pc[1] + 32'd4);
      end
      prev_hold   = imem_req[0] && !imem_gnt[0] && !branch_taken;
      prev_addr   = imem_addr[0];
      prev_branch = branch_taken;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    branch_taken   = 1'b0;
    branch_target  = '0;
    id_ready1      = 1'b1;
    branch_taken1  = 1'b0;
    branch_target1 = '0;
    gnt_en[0]  = 1'b1;
    gnt_en[1]  = 1'b1;
    mem_lat[0] = 1;
    mem_lat[1] = 1;
    tick();
    tick();

    // Reset state
    check("rst_req", {31'd0, imem_req[0]}, 32'd0);
    check("rst_addr", imem_addr[0], 32'h0);
    check("rst_valid", {31'd0, id_valid[0]}, 32'd0);
    check("rst_instr", id_instr[0], 32'h0);
    check("rst_pc", id_pc[0], 32'h0);
    check("rst_pc_plus4", id_pc_plus4[0], 32'h0);
    check("rst_opcode", {26'd0, id_opcode[0]}, 32'd0);
    check("rst1_addr", imem_addr[1], 32'hFFFF_FFFC);

    // First fetch: idle cycle, request in the second cycle
    rst_n = 1'b1;
    check("first_idle_req", {31'd0, imem_req[0]}, 32'd0);
    tick();
    check("first_req", {31'd0, imem_req[0]}, 32'd1);
    check("first_addr", imem_addr[0], 32'h0);
    tick();
    check("wait_req", {31'd0, imem_req[0]}, 32'd0);
    tick();
    check("first_valid", {31'd0, id_valid[0]}, 32'd1);
    check("first_pc", id_pc[0], 32'h0);
    check("first_pc_plus4", id_pc_plus4[0], 32'h4);
    check("first_opcode", {26'd0, id_opcode[0]}, 32'h23);
    check("first_instr", id_instr[0], 32'h8C08_0004);
    check("second_req", {31'd0, imem_req[0]}, 32'd1);
    check("second_addr", imem_addr[0], 32'h4);
    check("wrap_pc", id_pc[1], 32'hFFFF_FFFC);
    check("wrap_pc_plus4", id_pc_plus4[1], 32'h0);
    check("wrap_next_req", {31'd0, imem_req[1]}, 32'd1);
    check("wrap_next_addr", imem_addr[1], 32'h0);

    // Stream: one instruction every two cycles
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("stream_gap", {31'd0, id_valid[0]}, 32'd0);
      tick();
      check("stream_valid", {31'd0, id_valid[0]}, 32'd1);
      check("stream_pc", id_pc[0], 32'(4 * k));
    end

    // Backpressure: second response lands in the skid slot
    id_ready = 1'b0;
    tick();
    check("bp_wait_req", {31'd0, imem_req[0]}, 32'd0);
    tick();
    check("hold_req", {31'd0, imem_req[0]}, 32'd0);
    check("hold_pc", id_pc[0], 32'hC);
    check("hold_instr", id_instr[0], instr_at(32'hC));
    tick();
    check("hold2_req", {31'd0, imem_req[0]}, 32'd0);
    check("hold2_pc", id_pc[0], 32'hC);
    id_ready = 1'b1;
    tick();
    check("skid_valid", {31'd0, id_valid[0]}, 32'd1);
    check("skid_pc", id_pc[0], 32'h10);
    check("skid_instr", id_instr[0], instr_at(32'h10));
    check("skid_next_req", {31'd0, imem_req[0]}, 32'd1);
    check("skid_next_addr", imem_addr[0], 32'h14);

    // Back into S_HOLD, then asynchronous reset mid-cycle
    id_ready = 1'b0;
    tick();
    tick();
    check("hold3_req", {31'd0, imem_req[0]}, 32'd0);
    check("hold3_pc", id_pc[0], 32'h10);
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", {31'd0, id_valid[0]}, 32'd0);
    check("async_req", {31'd0, imem_req[0]}, 32'd0);
    check("async_addr", imem_addr[0], 32'h0);
    tick();
    tick();
    rst_n    = 1'b1;
    id_ready = 1'b1;
    check("re_idle_req", {31'd0, imem_req[0]}, 32'd0);
    tick();
    check("re_req", {31'd0, imem_req[0]}, 32'd1);
    check("re_addr", imem_addr[0], 32'h0);
    tick();
    tick();
    check("re_pc", id_pc[0], 32'h0);
    tick();
    tick();
    check("re2_valid", {31'd0, id_valid[0]}, 32'd1);
    check("re2_pc", id_pc[0], 32'h4);
    check("re2_addr", imem_addr[0], 32'h8);

    // Redirect while the fetch of 8 is outstanding (2-cycle memory)
    id_ready   = 1'b0;
    mem_lat[0] = 2;
    tick();
    check("br_before_valid", {31'd0, id_valid[0]}, 32'd1);
    check("br_before_req", {31'd0, imem_req[0]}, 32'd0);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0043;
    tick();
    branch_taken = 1'b0;
    id_ready     = 1'b1;
    mem_lat[0]   = 1;
    gnt_en[0]    = 1'b0;
    check("br_flush_valid", {31'd0, id_valid[0]}, 32'd0);
    check("br_drop_req", {31'd0, imem_req[0]}, 32'd0);
    check("br_stale_rvalid", {31'd0, imem_rvalid[0]}, 32'd1);
    tick();
    check("br_dropped_valid", {31'd0, id_valid[0]}, 32'd0);
    check("br_req", {31'd0, imem_req[0]}, 32'd1);
    check("br_addr", imem_addr[0], 32'h40);
    tick();
    check("stall_req", {31'd0, imem_req[0]}, 32'd1);
    check("stall_addr", imem_addr[0], 32'h40);
    gnt_en[0] = 1'b1;
    tick();
    check("br_wait_req", {31'd0, imem_req[0]}, 32'd0);
    tick();
    check("br_tgt_valid", {31'd0, id_valid[0]}, 32'd1);
    check("br_tgt_pc", id_pc[0], 32'h40);
    check("br_tgt_instr", id_instr[0], instr_at(32'h40));

    for (int i = 0; i < 4; i++) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
